vertex_buffer_pingpong: RTL
===========================

// Module: vertex_buffer_pingpong
// PURPOSE
//  Parametrised, double-banked feature-vector accumulator between the Vertex PE and the Output Buffer.
//  Streamed partial sums are accumulated per FV element into a fill bank.
//  A closed bank is drained OUT_LANES elements/beat under a req/grant handshake to the Output SRAM.
//  Two banks: ingest of node N+1 overlaps drain of node N.
// PARAMETERS
//  FV_SIZE     16  width of one FV element, two's-complement signed
//  MAX_FV_NUM  16  max elements per feature vector (bank depth)
//  OUT_LANES   2   elements per output beat; power of two, <= MAX_FV_NUM
//  NODEID_W    10  node id width
//  SAT_EN      1   1: saturating accumulate; 0: wrap-around modulo 2^FV_SIZE
// PORTS
//  clk           in   1                    clock; all logic on posedge
//  reset         in   1                    synchronous, active-high
//  in_valid      in   1                    input beat valid
//  in_sos        in   1                    beat is first of a node (start of stream)
//  in_eos        in   1                    beat is last of a node (end of stream)
//  in_change     in   1                    advance element index after this beat
//  in_data       in   FV_SIZE              partial sum to accumulate
//  in_nodeid     in   NODEID_W             node id; sampled on sos beat
//  in_ready      out  1                    fill bank available; beat accepted iff in_valid&in_ready
//  out_req       out  1                    request Output SRAM port
//  out_grant     in   1                    grant from Output SRAM arbiter
//  out_valid     out  1                    output beat valid
//  out_sos       out  1                    first output beat
//  out_eos       out  1                    last output beat
//  out_nodeid    out  NODEID_W             node id of the bank being drained
//  out_data      out  OUT_LANES*FV_SIZE    lane k = bits [k*FV_SIZE +: FV_SIZE]
//  out_fv_num    out  $clog2(MAX_FV_NUM)+1 element count of the bank being drained
//  busy          out  1                    any bank full, or fill in progress, or drain FSM not IDLE
//  err           out  1                    sticky: index overflow or sos mid-vector; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1. Banks, indices, full flags, nodeids and err are cleared.
//   A reset mid-operation discards partial and full banks; out_valid is 0 in the cycle after reset.
//  Fill side (wr_bank, wr_idx, in_prog); an accepted beat does:
//   - bank[wr_bank][wr_idx] += in_data. With SAT_EN, clamp to [-2^(FV_SIZE-1), 2^(FV_SIZE-1)-1].
//   - in_sos: the beat writes index 0, captures in_nodeid, sets in_prog.
//     If in_prog was already set, also set err; bank contents are kept.
//   - in_change (without eos): wr_idx++ after the write.
//     If wr_idx==MAX_FV_NUM-1, wr_idx holds and err sets.
//   - in_eos: fv_num[wr_bank]=wr_idx+1, full[wr_bank]=1, wr_bank toggles, wr_idx=0, in_prog=0.
//     in_change is ignored on that beat.
//   - in_sos & in_eos on the same beat: single-element node, fv_num=1.
//   - Beats with in_valid & !in_sos & !in_prog are dropped and set err.
//  in_ready = !full[wr_bank] (combinational from registered flags).
//  Drain FSM, registered: IDLE -> REQ -> STREAM -> IDLE.
//   - IDLE: if full[rd_bank], go to REQ next cycle. rd_bank is the oldest full bank (banks alternate).
//   - REQ: out_req=1. When out_grant is sampled high, go to STREAM next cycle with rd_idx=0.
//     out_req is 0 from the STREAM cycle on. out_grant outside REQ is ignored.
//   - STREAM: out_valid=1 every cycle, no backpressure.
//     Lane k = bank[rd_bank][rd_idx+k]; lanes with index >= fv_num drive 0.
//     out_sos=1 on the rd_idx==0 beat. out_eos=1 when rd_idx+OUT_LANES >= fv_num.
//     rd_idx += OUT_LANES per beat; beats per node = ceil(fv_num/OUT_LANES).
//     On the eos beat edge: zero bank[rd_bank], clear full[rd_bank], toggle rd_bank, go to IDLE.
//  out_nodeid and out_fv_num are valid during REQ and STREAM, and 0 in IDLE.
//  Latency: eos accepted at edge T -> full at T -> FSM in REQ (out_req=1) after edge T+1.
//   Grant sampled at edge G -> out_sos beat in cycle G+1.
//  Simultaneous events:
//   - Fill and drain act on different banks and proceed in the same cycle.
//   - When the drain clears full[x] at edge E and wr_bank==x, in_ready rises in cycle E+1.
//  The drained bank is zero before reuse, so the first accumulate equals the input.
// TESTING
//  1 Default params. sos(node 5, d=3), then d=4 with change, then d=10, eos(d=1); grant at once.
//    -> out_req 2 cycles after eos; 1 beat, lanes {7,11}, sos=eos=1, nodeid 5, fv_num 2.
//  2 fv_num=5, OUT_LANES=2, elements 1..5 -> 3 beats {1,2},{3,4},{5,0}; sos on beat 1 only, eos on beat 3 only.
//  3 Hold out_grant low; send two full nodes -> in_ready=0 after the second eos.
//    Third node's sos is stalled until the first drain's eos; no data loss, FIFO drain order.
//  4 SAT_EN=1: 0x7FF0 + 0x0100 -> 0x7FFF; 0x8010 + 0xFF00 -> 0x8000.
//    SAT_EN=0: 0x7FF0 + 0x0100 -> 0x80F0.
//  5 MAX_FV_NUM changes without eos -> err=1, wr_idx saturates at 15.
//    sos during an open vector -> err stays 1.
//  6 Assert reset during STREAM beat 2 -> next cycle out_valid=0, out_req=0, in_ready=1, err=0.
//    A fresh node then drains correctly from zeroed banks.

Source files
------------

// File: rtl/vertex_buffer_pingpong.sv
// Double-banked feature-vector accumulator: one bank accumulates streamed partial sums
// while the other, closed bank is drained OUT_LANES elements per beat to the Output SRAM.
//
//   state    | meaning
//   S_IDLE   | waiting for the oldest bank (rd_bank) to become full
//   S_REQ    | out_req asserted, waiting for out_grant
//   S_STREAM | one output beat per cycle until the eos beat, then bank is zeroed and released
module vertex_buffer_pingpong #(
    parameter int FV_SIZE    = 16,
    parameter int MAX_FV_NUM = 16,
    parameter int OUT_LANES  = 2,
    parameter int NODEID_W   = 10,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_sos,
    input  logic                           in_eos,
    input  logic                           in_change,
    input  logic [FV_SIZE-1:0]             in_data,
    input  logic [NODEID_W-1:0]            in_nodeid,
    output logic                           in_ready,
    output logic                           out_req,
    input  logic                           out_grant,
    output logic                           out_valid,
    output logic                           out_sos,
    output logic                           out_eos,
    output logic [NODEID_W-1:0]            out_nodeid,
    output logic [OUT_LANES*FV_SIZE-1:0]   out_data,
    output logic [$clog2(MAX_FV_NUM):0]    out_fv_num,
    output logic                           busy,
    output logic                           err
);

    localparam int IDX_W = $clog2(MAX_FV_NUM);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STREAM
    } state_t;

    state_t state, state_nx;

    logic [FV_SIZE-1:0]  bank [2][MAX_FV_NUM];
    logic [CNT_W-1:0]    fv_num [2];
    logic [NODEID_W-1:0] nodeid [2];
    logic [1:0]          full;

    logic                wr_bank;
    logic [IDX_W-1:0]    wr_idx;
    logic                in_prog;
    logic                rd_bank;
    logic [CNT_W-1:0]    rd_idx;

    logic                accept;
    logic                write_en;
    logic [IDX_W-1:0]    wr_pos;
    logic [FV_SIZE-1:0]  acc_val;
    logic                drain_done;
    logic [CNT_W:0]      lane_pos;

    function automatic logic [FV_SIZE-1:0] acc_add(input logic [FV_SIZE-1:0] a,
                                                   input logic [FV_SIZE-1:0] b);
        logic [FV_SIZE:0] s;
        s = {a[FV_SIZE-1], a} + {b[FV_SIZE-1], b};
        if (SAT_EN && (s[FV_SIZE] != s[FV_SIZE-1])) begin
            // Sign of the wide sum tells which rail was crossed
            if (s[FV_SIZE])
                return {1'b1, {(FV_SIZE-1){1'b0}}};
            else
                return {1'b0, {(FV_SIZE-1){1'b1}}};
        end
        return s[FV_SIZE-1:0];
    endfunction

    assign in_ready   = !full[wr_bank];
    assign accept     = in_valid && in_ready;
    assign write_en   = accept && (in_sos || in_prog);
    assign wr_pos     = in_sos ? '0 : wr_idx;
    assign acc_val    = acc_add(bank[wr_bank][wr_pos], in_data);

    assign out_req    = (state == S_REQ);
    assign out_valid  = (state == S_STREAM);
    assign out_sos    = (state == S_STREAM) && (rd_idx == '0);
    assign out_eos    = (state == S_STREAM) &&
                        (({1'b0, rd_idx} + (CNT_W+1)'(OUT_LANES)) >= {1'b0, fv_num[rd_bank]});
    assign out_nodeid = (state != S_IDLE) ? nodeid[rd_bank] : '0;
    assign out_fv_num = (state != S_IDLE) ? fv_num[rd_bank] : '0;
    assign drain_done = out_eos;
    assign busy       = (|full) || in_prog || (state != S_IDLE);

    always_comb begin
        out_data = '0;
        lane_pos = '0;
        if (state == S_STREAM) begin
            for (int k = 0; k < OUT_LANES; k++) begin
                lane_pos = {1'b0, rd_idx} + (CNT_W+1)'(k);
                if (lane_pos < {1'b0, fv_num[rd_bank]})
                    out_data[k*FV_SIZE +: FV_SIZE] = bank[rd_bank][lane_pos[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (full[rd_bank]) state_nx = S_REQ;
            S_REQ:    if (out_grant)     state_nx = S_STREAM;
            S_STREAM: if (out_eos)       state_nx = S_IDLE;
            default:                     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MAX_FV_NUM; i++)
                    bank[b][i] <= '0;
                fv_num[b] <= '0;
                nodeid[b] <= '0;
            end
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            in_prog <= 1'b0;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            err     <= 1'b0;
        end else begin
            // Fill and drain always target different banks, so these never collide
            if (write_en)
                bank[wr_bank][wr_pos] <= acc_val;
            if (drain_done) begin
                for (int i = 0; i < MAX_FV_NUM; i++)
                    bank[rd_bank][i] <= '0;
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end

            if (accept) begin
                if (!in_sos && !in_prog) begin
                    err <= 1'b1;
                end else begin
                    if (in_sos) begin
                        nodeid[wr_bank] <= in_nodeid;
                        if (in_prog)
                            err <= 1'b1;
                    end
                    if (in_eos) begin
                        fv_num[wr_bank] <= CNT_W'(wr_pos) + CNT_W'(1);
                        full[wr_bank]   <= 1'b1;
                        wr_bank         <= ~wr_bank;
                        wr_idx          <= '0;
                        in_prog         <= 1'b0;
                    end else begin
                        in_prog <= 1'b1;
                        if (in_change) begin
                            if (wr_pos == IDX_W'(MAX_FV_NUM-1)) begin
                                wr_idx <= wr_pos;
                                err    <= 1'b1;
                            end else begin
                                wr_idx <= wr_pos + IDX_W'(1);
                            end
                        end else begin
                            wr_idx <= wr_pos;
                        end
                    end
                end
            end

            if (state == S_REQ)
                rd_idx <= '0;
            else if (state == S_STREAM)
                rd_idx <= rd_idx + CNT_W'(OUT_LANES);
        end
    end

endmodule
